// File: rtl/ss_pkg.sv
// ---------------------------------------------------------------------------
// ss_pkg
// Shared definitions for the stochastic-symbol frame accumulator:
//   - frame FSM state encoding (IDLE / ACCUM / HOLD)
//   - default symbol width and frame size
//   - accumulator width derivation
// ---------------------------------------------------------------------------
package ss_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_ACCUM = ACCUM,
        ST_HOLD  = HOLD
    } state_t;

    localparam int SS_W_DEF       = 4;
    localparam int FRAME_LOG2_DEF = 8;

    // A frame of 2^frame_log2 symbols, each at most 2^ss_w-1, always fits in
    // ss_w+frame_log2 bits, so the accumulator never needs overflow handling.
    function automatic int acc_width(input int ss_w, input int frame_log2);
        return ss_w + frame_log2;
    endfunction

endpackage

// File: rtl/ss_frame_counter.sv
// ---------------------------------------------------------------------------
// ss_frame_counter
// Counts accepted symbols within a frame and flags the final one.
// Ports:
//   clk, rst  clock, asynchronous active-low reset
//   clr       synchronous clear to zero (wins over en)
//   en        count one accepted symbol
//   cnt       current count, 0 .. 2^FRAME_LOG2 (saturates at full frame)
//   tc        high while cnt == 2^FRAME_LOG2 - 1, i.e. the next accepted
//             symbol completes the frame
// ---------------------------------------------------------------------------
module ss_frame_counter #(
    parameter int FRAME_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    output logic [FRAME_LOG2:0]   cnt,
    output logic                  tc
);

    localparam logic [FRAME_LOG2:0] FULL = {1'b1, {FRAME_LOG2{1'b0}}};
    localparam logic [FRAME_LOG2:0] LAST = {1'b0, {FRAME_LOG2{1'b1}}};

    logic [FRAME_LOG2:0] cnt_q;
    logic [FRAME_LOG2:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != FULL)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/ss_frame_accumulator.sv
// ---------------------------------------------------------------------------
// ss_frame_accumulator
// Sums exactly 2^FRAME_LOG2 valid product symbols per frame after a start
// command, then presents the frame sum and mean on a valid/ready port.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   start         one-cycle frame start request (IDLE, or HOLD with handshake)
//   clear         synchronous abort back to IDLE, highest priority
//   ss_valid      qualifies z_ss; consumed only while accumulating
//   z_ss          product symbol
//   busy          high while accumulating
//   result_valid  high while a finished frame is held
//   result_ready  downstream accept
//   sum_out       frame sum
//   mean_out      sum_out >> FRAME_LOG2 (truncated)
//   sample_cnt    symbols accepted in the current frame
// ---------------------------------------------------------------------------
module ss_frame_accumulator
    import ss_pkg::*;
#(
    parameter  int SS_W       = SS_W_DEF,
    parameter  int FRAME_LOG2 = FRAME_LOG2_DEF,
    localparam int ACC_W      = acc_width(SS_W, FRAME_LOG2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  ss_valid,
    input  logic [SS_W-1:0]       z_ss,
    output logic                  busy,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [ACC_W-1:0]      sum_out,
    output logic [SS_W-1:0]       mean_out,
    output logic [FRAME_LOG2:0]   sample_cnt
);

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    sum_q, sum_d;
    logic [SS_W-1:0]     mean_q, mean_d;
    logic                busy_q, busy_d;
    logic                result_valid_q, result_valid_d;

    logic                cnt_clr;
    logic                cnt_en;
    logic                cnt_tc;
    logic [ACC_W-1:0]    acc_plus;

    ss_frame_counter #(
        .FRAME_LOG2 (FRAME_LOG2)
    ) u_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (sample_cnt),
        .tc  (cnt_tc)
    );

    // Running sum including the symbol presented this cycle.
    assign acc_plus = acc_q + {{FRAME_LOG2{1'b0}}, z_ss};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        mean_d  = mean_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        if (clear) begin
            // Abort: results from the previous frame are left visible.
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_ACCUM;
                        acc_d   = '0;
                        cnt_clr = 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (ss_valid) begin
                        acc_d  = acc_plus;
                        cnt_en = 1'b1;
                        if (cnt_tc) begin
                            state_d = ST_HOLD;
                            sum_d   = acc_plus;
                            mean_d  = SS_W'(acc_plus >> FRAME_LOG2);
                        end
                    end
                end
                ST_HOLD: begin
                    // A start that coincides with the accepting handshake
                    // launches the next frame back-to-back.
                    if (result_ready) begin
                        if (start) begin
                            state_d = ST_ACCUM;
                            acc_d   = '0;
                            cnt_clr = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_clr = 1'b1;
                end
            endcase
        end

        busy_d         = (state_d == ST_ACCUM);
        result_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            acc_q          <= '0;
            sum_q          <= '0;
            mean_q         <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            sum_q          <= sum_d;
            mean_q         <= mean_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign sum_out      = sum_q;
    assign mean_out     = mean_q;

endmodule

// File: tb/tb_ss_frame_accumulator.sv
// ---------------------------------------------------------------------------
// tb_ss_frame_accumulator
// Directed bench for ss_frame_accumulator: a default build (256-symbol
// frames) and a FRAME_LOG2=2 build sharing clock and reset.
// ---------------------------------------------------------------------------
module tb_ss_frame_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // Default build
    logic        start = 1'b0, clear = 1'b0, ss_valid = 1'b0, result_ready = 1'b0;
    logic [3:0]  z_ss = '0;
    logic        busy, result_valid;
    logic [11:0] sum_out;
    logic [3:0]  mean_out;
    logic [8:0]  sample_cnt;

    // FRAME_LOG2 = 2 build
    logic        start2 = 1'b0, clear2 = 1'b0, ss_valid2 = 1'b0, result_ready2 = 1'b0;
    logic [3:0]  z_ss2 = '0;
    logic        busy2, result_valid2;
    logic [5:0]  sum_out2;
    logic [3:0]  mean_out2;
    logic [2:0]  sample_cnt2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ss_frame_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .clear        (clear),
        .ss_valid     (ss_valid),
        .z_ss         (z_ss),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .sum_out      (sum_out),
        .mean_out     (mean_out),
        .sample_cnt   (sample_cnt)
    );

    ss_frame_accumulator #(
        .SS_W       (4),
        .FRAME_LOG2 (2)
    ) dut2 (
        .clk          (clk),
        .rst          (rst),
        .start        (start2),
        .clear        (clear2),
        .ss_valid     (ss_valid2),
        .z_ss         (z_ss2),
        .busy         (busy2),
        .result_valid (result_valid2),
        .result_ready (result_ready2),
        .sum_out      (sum_out2),
        .mean_out     (mean_out2),
        .sample_cnt   (sample_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        $display("check %-20s observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #12;
        check("rst_busy",  busy,         0);
        check("rst_rv",    result_valid, 0);
        check("rst_sum",   sum_out,      0);
        check("rst_mean",  mean_out,     0);
        check("rst_cnt",   sample_cnt,   0);
        tick();
        rst = 1'b1;

        // ---------------- frame of 256 x 9 ----------------
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_cnt0", sample_cnt, 0);
        ss_valid = 1'b1;
        z_ss     = 4'd9;
        for (int i = 0; i < 255; i++) tick();
        check("t1_cnt255", sample_cnt, 255);
        check("t1_rv_early", result_valid, 0);
        tick();
        ss_valid = 1'b0;
        check("t1_rv",   result_valid, 1);
        check("t1_busy_hold", busy, 0);
        check("t1_sum",  sum_out, 2304);
        check("t1_mean", mean_out, 9);
        check("t1_cnt",  sample_cnt, 256);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("t1_rv_done", result_valid, 0);
        check("t1_idle_busy", busy, 0);

        // ---------------- gapped 0/4 frame ----------------
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 510; i++) begin
            ss_valid = (i % 2 == 0);
            z_ss     = (((i / 2) % 2) == 1) ? 4'd4 : 4'd0;
            tick();
        end
        check("t2_cnt255", sample_cnt, 255);
        check("t2_rv_early", result_valid, 0);
        ss_valid = 1'b1;
        z_ss     = 4'd4;
        tick();
        ss_valid = 1'b0;
        check("t2_rv",   result_valid, 1);
        check("t2_sum",  sum_out, 512);
        check("t2_mean", mean_out, 2);

        // ---------------- HOLD back-pressure with start toggling ----------------
        for (int i = 0; i < 20; i++) begin
            start = (i % 2 == 0);
            tick();
        end
        start = 1'b0;
        check("t3_rv",   result_valid, 1);
        check("t3_busy", busy, 0);
        check("t3_sum",  sum_out, 512);
        check("t3_mean", mean_out, 2);
        check("t3_cnt",  sample_cnt, 256);
        start        = 1'b1;
        result_ready = 1'b1;
        tick();
        start        = 1'b0;
        result_ready = 1'b0;
        check("t3_b2b_busy", busy, 1);
        check("t3_b2b_rv",   result_valid, 0);
        check("t3_b2b_cnt",  sample_cnt, 0);

        // ---------------- clear after 100 symbols ----------------
        ss_valid = 1'b1;
        z_ss     = 4'd1;
        for (int i = 0; i < 100; i++) tick();
        check("t4_cnt100", sample_cnt, 100);
        ss_valid = 1'b0;
        clear    = 1'b1;
        tick();
        clear = 1'b0;
        check("t4_clr_busy", busy, 0);
        check("t4_clr_cnt",  sample_cnt, 0);
        check("t4_clr_sum",  sum_out, 512);
        start = 1'b1;
        tick();
        start    = 1'b0;
        ss_valid = 1'b1;
        z_ss     = 4'd2;
        for (int i = 0; i < 256; i++) tick();
        ss_valid = 1'b0;
        check("t4_rv",   result_valid, 1);
        check("t4_sum",  sum_out, 512);
        check("t4_mean", mean_out, 2);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        // clear together with start stays in IDLE
        start = 1'b1;
        clear = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        check("t4_clr_start_busy", busy, 0);

        // ---------------- FRAME_LOG2=2 build: 3,1,0,2 ----------------
        start2 = 1'b1;
        tick();
        start2    = 1'b0;
        ss_valid2 = 1'b1;
        z_ss2 = 4'd3; tick();
        z_ss2 = 4'd1; tick();
        z_ss2 = 4'd0; tick();
        check("t6_rv_early", result_valid2, 0);
        z_ss2 = 4'd2; tick();
        ss_valid2 = 1'b0;
        check("t6_rv",   result_valid2, 1);
        check("t6_sum",  sum_out2, 6);
        check("t6_mean", mean_out2, 1);
        check("t6_cnt",  sample_cnt2, 4);

        // ---------------- asynchronous reset mid-frame ----------------
        start = 1'b1;
        tick();
        start    = 1'b0;
        ss_valid = 1'b1;
        z_ss     = 4'd5;
        for (int i = 0; i < 10; i++) tick();
        check("t5_busy_pre", busy, 1);
        #3;
        rst = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_rv",   result_valid, 0);
        check("t5_sum",  sum_out, 0);
        check("t5_cnt",  sample_cnt, 0);
        check("t5_rv2",  result_valid2, 0);
        ss_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("t5_after_busy", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ss_frame_accumulator.md
Name: ss_frame_accumulator

Overview:
- Downstream consumer of the 2-bit stochastic-symbol multiplier product stream (4-bit z_ss, values 0..9).
- Accumulates exactly 2^FRAME_LOG2 valid symbols per frame after a start command, then presents the frame sum and the frame mean on a valid/ready output port.
- Replaces free-running accumulation with bounded, restartable frames so results can be handed to the next stage deterministically.

Parameters:
- SS_W, 4, width of incoming product symbol z_ss.
- FRAME_LOG2, 8, log2 of symbols per frame (default 256).
- ACC_W, SS_W+FRAME_LOG2 (12), accumulator / sum width; derived, never overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle frame start request.
- clear  input  1  synchronous abort; returns to IDLE.
- ss_valid  input  1  z_ss qualifier; symbol consumed only when high during ACCUM.
- z_ss  input  SS_W  product symbol from multiplier.
- busy  output  1  high in ACCUM.
- result_valid  output  1  high in HOLD.
- result_ready  input  1  downstream accept.
- sum_out  output  ACC_W  frame sum.
- mean_out  output  SS_W  sum_out >> FRAME_LOG2 (truncated).
- sample_cnt  output  FRAME_LOG2+1  symbols accepted in the current frame.

Behaviour:
- Reset (rst=0, async): state=IDLE; acc, sum_out, mean_out, sample_cnt=0; busy=0; result_valid=0.
- States: IDLE, ACCUM, HOLD. All outputs registered.
- IDLE: start=1 -> ACCUM next cycle; acc and sample_cnt cleared on the same edge. Other inputs ignored.
- ACCUM: each edge with ss_valid=1 does acc += z_ss (zero-extended) and sample_cnt += 1. ss_valid=0 leaves both unchanged (gaps allowed, no timeout).
- Frame end: on the edge that accepts symbol number 2^FRAME_LOG2 -> HOLD; sum_out = final acc including that symbol; mean_out = that sum >> FRAME_LOG2; result_valid=1 from the next cycle. Latency: result_valid rises 1 cycle after the last accepted symbol.
- Width: max sum = (2^SS_W - 1)*2^FRAME_LOG2 fits ACC_W exactly, so no overflow or saturation logic is needed. Legal product values 0..9 give sum ≤ 2304 at defaults.
- HOLD: sum_out/mean_out stable while result_valid=1. Transfer completes on an edge with result_valid&result_ready -> IDLE, result_valid=0.
- Simultaneous start with the handshake in HOLD: the new frame is accepted; go directly to ACCUM with acc and sample_cnt cleared, result_valid=0.
- start during ACCUM, or during HOLD without result_ready: ignored (no queueing).
- clear: highest priority in every state. Next state is IDLE; acc and sample_cnt=0; result_valid=0; sum_out/mean_out keep their last values. A clear coinciding with start stays in IDLE.
- Reset mid-frame: everything returns to the reset values immediately; the partial frame is discarded.
- sample_cnt saturates at 2^FRAME_LOG2 in HOLD and reads back the full frame count.

Decomposition:
- Shared package ss_pkg:
  - state encoding localparams (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2);
  - SS_W and FRAME_LOG2 defaults;
  - ACC_W derivation function.
- One natural sub-module: ss_frame_counter, which holds the sample counter with clear/enable and the terminal-count flag. The FSM and accumulator stay in the top module.

Test Plan:
- Reset, then start with z_ss=9 and ss_valid=1 for 256 cycles -> result_valid 1 cycle after the last symbol; sum_out=2304, mean_out=9, sample_cnt=256.
- z_ss alternating 0/4 with ss_valid toggling every cycle -> frame ends after the 256th valid symbol (~512 cycles); sum_out=512, mean_out=2.
- Hold result_ready=0 for 20 cycles in HOLD while toggling start -> outputs stable, no new frame. Then result_ready=1 together with start -> next cycle busy=1, result_valid=0, sample_cnt=0.
- clear asserted after 100 symbols of z_ss=1 -> IDLE next cycle, sample_cnt=0; a new start and 256 symbols of z_ss=2 give sum_out=512.
- rst driven low asynchronously mid-ACCUM (between edges) -> busy, result_valid, sum_out and sample_cnt go to 0 immediately.
- FRAME_LOG2=2 build, z_ss=3,1,0,2 -> sum_out=6, mean_out=1 (truncated), ACC_W=6.
